// File: rtl/ball_link_tx_pkg.sv
`timescale 1ns/1ps
// ball_link_pkg
// Shared definitions for the ball hand-off transmitter: FSM state encoding,
// frame geometry, the receiver's register map indices, the latched shadow
// record and the helper that turns a frame index into the byte on the wire.
//
// Frame on the wire (byte index 0..7):
//   0 address {SLAVE_ADDR,W}, 1 register pointer, 2..7 slv_reg0..slv_reg5
package ball_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_SEND,
        ST_WAIT_ACK,
        ST_STOP_OK,
        ST_DONE,
        ST_STOP_FAIL
    } state_t;

    localparam int         FRAME_BYTES  = 8;
    localparam logic [7:0] REG_PTR_BASE = 8'h00;

    // Address + pointer precede the register payload.
    localparam int HDR_BYTES = 2;

    // Receiver register map (slv_reg0..slv_reg5).
    localparam int REG_Y0    = 0;
    localparam int REG_Y1    = 1;
    localparam int REG_VY    = 2;
    localparam int REG_GRAV  = 3;
    localparam int REG_SPEED = 4;
    localparam int REG_WIN   = 5;

    typedef struct packed {
        logic [9:0] ball_y;
        logic [7:0] ball_vy;
        logic [1:0] gravity_counter;
        logic       speed_fast;
        logic       win_flag;
    } shadow_t;

    // Byte transmitted at frame position idx.
    function automatic logic [7:0] pack_byte(input logic [2:0] idx,
                                             input shadow_t    shadow,
                                             input logic [6:0] addr);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0:                      b = {addr, 1'b0};
            3'd1:                      b = REG_PTR_BASE;
            3'(HDR_BYTES + REG_Y0):    b = {shadow.ball_y[9:8], 6'b0};
            3'(HDR_BYTES + REG_Y1):    b = shadow.ball_y[7:0];
            3'(HDR_BYTES + REG_VY):    b = shadow.ball_vy;
            3'(HDR_BYTES + REG_GRAV):  b = {6'b0, shadow.gravity_counter};
            3'(HDR_BYTES + REG_SPEED): b = {7'b0, shadow.speed_fast};
            3'(HDR_BYTES + REG_WIN):   b = {7'b0, shadow.win_flag};
            default:                   b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ball_link_tx_if.sv
`timescale 1ns/1ps
// ball_link_tx_if
// Byte-level handshake between the frame transmitter and the I2C master core.
//   i2c_start / i2c_stop : one-cycle START / STOP requests (transmitter -> core)
//   i2c_wdata / i2c_wvalid: byte offered, held until i2c_wready
//   i2c_wready           : core accepts the byte when wvalid && wready
//   i2c_ack_valid        : one-cycle pulse, ACK slot of the last byte finished
//   i2c_nack             : qualifies i2c_ack_valid, 1 = NACK
//   i2c_busy             : core is on the bus
// Modports: master = transmitter side, slave = I2C core side.
interface ball_link_tx_if;
    logic       i2c_start;
    logic       i2c_stop;
    logic [7:0] i2c_wdata;
    logic       i2c_wvalid;
    logic       i2c_wready;
    logic       i2c_ack_valid;
    logic       i2c_nack;
    logic       i2c_busy;

    modport master (
        output i2c_start, i2c_stop, i2c_wdata, i2c_wvalid,
        input  i2c_wready, i2c_ack_valid, i2c_nack, i2c_busy
    );

    modport slave (
        input  i2c_start, i2c_stop, i2c_wdata, i2c_wvalid,
        output i2c_wready, i2c_ack_valid, i2c_nack, i2c_busy
    );
endinterface

// File: rtl/ball_link_tx.sv
`timescale 1ns/1ps
// ball_link_tx
// Latches the ball hand-off state on a rising edge of the controller's send
// trigger and writes it as an 8-byte frame (address, pointer, slv_reg0..5)
// through a byte-level I2C master core.
//
// Ports:
//   clk_25MHZ, reset       : clock, asynchronous active-high reset
//   i_send_trigger         : level from the controller, rising edge starts a frame
//   i_ball_y/i_ball_vy/i_gravity_counter/i_speed_fast/i_win_flag : frame payload
//   i2c (master modport)   : START/STOP pulses, byte handshake, ACK status, busy
//   o_done                 : one-cycle pulse on a successfully completed frame
//   o_error                : sticky failure flag, cleared by the next trigger edge
//   o_busy                 : high whenever the FSM is not idle
//
// Build option BALL_TX_RETRY_EN: a NACKed frame is restarted from the address
// byte up to MAX_RETRY times (parameter only exists in that build); without it
// a NACK ends the frame with o_error.
module ball_link_tx
    import ball_link_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h42
`ifdef BALL_TX_RETRY_EN
    , parameter int MAX_RETRY = 3
`endif
) (
    input  logic                  clk_25MHZ,
    input  logic                  reset,
    input  logic                  i_send_trigger,
    input  logic [9:0]            i_ball_y,
    input  logic [7:0]            i_ball_vy,
    input  logic [1:0]            i_gravity_counter,
    input  logic                  i_speed_fast,
    input  logic                  i_win_flag,
    ball_link_tx_if.master        i2c,
    output logic                  o_done,
    output logic                  o_error,
    output logic                  o_busy
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    state_t     r_state;
    logic [2:0] r_idx;
    shadow_t    r_shadow;
    logic       r_trig_d;
    logic       r_start;
    logic       r_stop;
    logic       r_wvalid;
    logic [7:0] r_wdata;
    logic       r_done;
    logic       r_error;
    logic       w_trig_edge;

`ifdef BALL_TX_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RETRY_W-1:0] r_retry;
`endif

    // The edge detector runs in every state, so a level held high through a
    // frame never produces a late edge once the FSM is back in IDLE.
    assign w_trig_edge = i_send_trigger & ~r_trig_d;

    always_ff @(posedge clk_25MHZ or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_idx    <= 3'd0;
            r_shadow <= '0;
            r_trig_d <= 1'b0;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_wvalid <= 1'b0;
            r_wdata  <= 8'h00;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
`ifdef BALL_TX_RETRY_EN
            r_retry  <= '0;
`endif
        end else begin
            r_trig_d <= i_send_trigger;
            r_start  <= 1'b0;
            r_stop   <= 1'b0;
            r_done   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_trig_edge) begin
                        r_shadow <= '{ball_y:          i_ball_y,
                                      ball_vy:         i_ball_vy,
                                      gravity_counter: i_gravity_counter,
                                      speed_fast:      i_speed_fast,
                                      win_flag:        i_win_flag};
                        r_error  <= 1'b0;
                        r_idx    <= 3'd0;
`ifdef BALL_TX_RETRY_EN
                        r_retry  <= '0;
`endif
                        r_state  <= ST_START;
                    end
                end

                ST_START: begin
                    // The address byte is offered together with the START
                    // request; the core holds wready low until it is ready.
                    if (!i2c.i2c_busy) begin
                        r_start  <= 1'b1;
                        r_wvalid <= 1'b1;
                        r_wdata  <= pack_byte(3'd0, r_shadow, SLAVE_ADDR);
                        r_state  <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (i2c.i2c_wready) begin
                        r_wvalid <= 1'b0;
                        r_state  <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (i2c.i2c_ack_valid) begin
                        if (i2c.i2c_nack) begin
                            r_stop  <= 1'b1;
                            r_state <= ST_STOP_FAIL;
                        end else if (r_idx == LAST_IDX) begin
                            r_stop  <= 1'b1;
                            r_state <= ST_STOP_OK;
                        end else begin
                            r_idx    <= r_idx + 3'd1;
                            r_wvalid <= 1'b1;
                            r_wdata  <= pack_byte(r_idx + 3'd1, r_shadow, SLAVE_ADDR);
                            r_state  <= ST_SEND;
                        end
                    end
                end

                ST_STOP_OK: begin
                    // Busy is only trusted once the core has registered STOP.
                    if (!r_stop && !i2c.i2c_busy) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                ST_STOP_FAIL: begin
                    if (!r_stop && !i2c.i2c_busy) begin
`ifdef BALL_TX_RETRY_EN
                        if (r_retry < RETRY_W'(MAX_RETRY)) begin
                            r_retry <= r_retry + 1'b1;
                            r_idx   <= 3'd0;
                            r_state <= ST_START;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_IDLE;
                        end
`else
                        r_error <= 1'b1;
                        r_state <= ST_IDLE;
`endif
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign i2c.i2c_start  = r_start;
    assign i2c.i2c_stop   = r_stop;
    assign i2c.i2c_wvalid = r_wvalid;
    assign i2c.i2c_wdata  = r_wdata;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_busy         = (r_state != ST_IDLE);

endmodule
